// File: rtl/multi_debouncer.sv
// Per-channel two-flop synchroniser plus stability counter debouncer with
// optional registered edge strobes (enabled by MULTI_DEBOUNCER_EDGE_EN).
module multi_debouncer #(
  parameter int   CHANNELS      = 4,
  parameter int   STABLE_CYCLES = 500000,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                asynch_nreset,
  input  logic [CHANNELS-1:0] signal_input,
  output logic [CHANNELS-1:0] signal_output,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [CHANNELS-1:0] r_s0;
  logic [CHANNELS-1:0] r_s1;
  logic [CHANNELS-1:0] r_level;
  logic [CHANNELS-1:0] w_load;
  logic [CHANNELS-1:0] w_level_next;

  always_ff @(posedge clk or negedge asynch_nreset) begin
    if (!asynch_nreset) begin
      r_s0 <= {CHANNELS{RESET_LEVEL}};
      r_s1 <= {CHANNELS{RESET_LEVEL}};
    end else begin
      r_s0 <= signal_input;
      r_s1 <= r_s0;
    end
  end

  // Counter restarts whenever the synchroniser stages disagree, so any bounce
  // shorter than D+1 samples never reaches the load threshold.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge asynch_nreset) begin
      if (!asynch_nreset) begin
        r_cnt <= '0;
      end else if (r_s0[g] != r_s1[g]) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_load[g] = (r_cnt == CNT_MAX);
  end

  assign w_level_next = (w_load & r_s1) | (~w_load & r_level);

  always_ff @(posedge clk or negedge asynch_nreset) begin
    if (!asynch_nreset) begin
      r_level <= {CHANNELS{RESET_LEVEL}};
    end else begin
      r_level <= w_level_next;
    end
  end

  assign signal_output = r_level;

`ifdef MULTI_DEBOUNCER_EDGE_EN
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;

  // Strobes are computed from the same next-level term so they line up with
  // the cycle in which signal_output shows the new level.
  always_ff @(posedge clk or negedge asynch_nreset) begin
    if (!asynch_nreset) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_level_next & ~r_level;
      r_fall <= ~w_level_next & r_level;
    end
  end

  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
`else
  assign rise_pulse = '0;
  assign fall_pulse = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer (CHANNELS=4, STABLE_CYCLES=4); the
// reference derives each level from the last D+1 sampled inputs.
module tb_multi_debouncer;

  localparam int CH = 4;
  localparam int D  = 4;
`ifdef MULTI_DEBOUNCER_EDGE_EN
  localparam int EDGE = 1;
`else
  localparam int EDGE = 0;
`endif

  logic          clk = 1'b0;
  logic          asynch_nreset;
  logic [CH-1:0] signal_input;
  logic [CH-1:0] signal_output;
  logic [CH-1:0] rise_pulse;
  logic [CH-1:0] fall_pulse;

  always #5 clk = ~clk;

  multi_debouncer #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (D),
    .RESET_LEVEL   (1'b0)
  ) dut (
    .clk           (clk),
    .asynch_nreset (asynch_nreset),
    .signal_input  (signal_input),
    .signal_output (signal_output),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: recent input samples (oldest first) and expected level
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_level;
  logic [3*CH-1:0] exp_q[$];
  logic [CH-1:0] prev_out;
  int cyc = 0;
  int last_rise_cyc[CH];
  int rise_cnt[CH];
  int fall_cnt[CH];

  function automatic void model_reset();
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
    m_level = '0;
    exp_q.delete();
  endfunction

  function automatic void clear_counts();
    for (int c = 0; c < CH; c++) begin
      rise_cnt[c] = 0;
      fall_cnt[c] = 0;
      last_rise_cyc[c] = -1;
    end
  endfunction

  task automatic step(input logic [CH-1:0] v);
    logic [CH-1:0]   nl;
    logic [CH-1:0]   r;
    logic [CH-1:0]   f;
    logic [3*CH-1:0] e;
    logic            same;
    @(negedge clk);
    signal_input = v;
    nl = m_level;
    if (hist.size() == D + 2) begin
      for (int c = 0; c < CH; c++) begin
        same = 1'b1;
        for (int j = 1; j <= D; j++) begin
          if (hist[j][c] != hist[0][c]) same = 1'b0;
        end
        if (same) nl[c] = hist[0][c];
      end
    end
    r = nl & ~m_level;
    f = ~nl & m_level;
    if (EDGE == 0) begin
      r = '0;
      f = '0;
    end
    m_level = nl;
    hist.push_back(v);
    while (hist.size() > D + 2) void'(hist.pop_front());
    exp_q.push_back({nl, r, f});
    @(posedge clk);
    cyc++;
    #1;
    e = exp_q.pop_front();
    check_val("level", 32'(signal_output), 32'(e[3*CH-1:2*CH]));
    check_val("rise", 32'(rise_pulse), 32'(e[2*CH-1:CH]));
    check_val("fall", 32'(fall_pulse), 32'(e[CH-1:0]));
    for (int c = 0; c < CH; c++) begin
      if (rise_pulse[c]) rise_cnt[c]++;
      if (fall_pulse[c]) fall_cnt[c]++;
      if (signal_output[c] && !prev_out[c]) last_rise_cyc[c] = cyc;
    end
    prev_out = signal_output;
  endtask

  // Asserts reset between clock edges, checks outputs clear at once, then
  // releases it mid-cycle so the next step() edge is the first active one.
  task automatic pulse_reset(input int hold_edges);
    #2;
    asynch_nreset = 1'b0;
    #1;
    model_reset();
    check_val("rst_level", 32'(signal_output), 32'(0));
    check_val("rst_rise", 32'(rise_pulse), 32'(0));
    check_val("rst_fall", 32'(fall_pulse), 32'(0));
    repeat (hold_edges) @(posedge clk);
    #1;
    check_val("rst_hold_level", 32'(signal_output), 32'(0));
    #1;
    asynch_nreset = 1'b1;
    prev_out = '0;
  endtask

  initial begin
    int s;
    logic [CH-1:0] v;
    signal_input  = '0;
    asynch_nreset = 1'b0;
    prev_out      = '0;
    model_reset();
    clear_counts();
    pulse_reset(2);

    // Clean step on ch0
    repeat (6) step('0);
    clear_counts();
    step(4'b0001);
    s = cyc;
    repeat (10) step(4'b0001);
    check_val("lat_ch0", 32'(last_rise_cyc[0] - s), 32'(D + 2));
    check_val("rise_cnt_ch0", 32'(rise_cnt[0]), 32'(EDGE));

    // Glitch on ch1 shorter than D+1 samples
    clear_counts();
    repeat (3) step(4'b0011);
    repeat (10) step(4'b0001);
    check_val("glitch_rise_ch1", 32'(rise_cnt[1]), 32'(0));
    check_val("glitch_fall_ch1", 32'(fall_cnt[1]), 32'(0));

    // Bounce on ch2 then settle high
    clear_counts();
    for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 4'b0101 : 4'b0001);
    step(4'b0101);
    s = cyc;
    repeat (10) step(4'b0101);
    check_val("lat_ch2", 32'(last_rise_cyc[2] - s), 32'(D + 2));
    check_val("rise_cnt_ch2", 32'(rise_cnt[2]), 32'(EDGE));

    // All channels rise together
    repeat (10) step('0);
    clear_counts();
    step(4'b1111);
    s = cyc;
    repeat (8) step(4'b1111);
    for (int c = 0; c < CH; c++) begin
      check_val("lat_all", 32'(last_rise_cyc[c] - s), 32'(D + 2));
      check_val("rise_cnt_all", 32'(rise_cnt[c]), 32'(EDGE));
    end

    // ch3 falls for 2 samples, then reset lands mid-count
    clear_counts();
    repeat (2) step(4'b0111);
    pulse_reset(1);
    repeat (8) step('0);
    check_val("no_fall_ch3", 32'(fall_cnt[3]), 32'(0));

    // Partial count discarded by reset while inputs are held high
    repeat (3) step(4'b1111);
    pulse_reset(1);
    clear_counts();
    step(4'b1111);
    s = cyc;
    repeat (8) step(4'b1111);
    check_val("lat_after_rst", 32'(last_rise_cyc[0] - s), 32'(D + 2));

    // Random bouncing with occasional long holds
    v = '0;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) v = CH'($urandom_range(0, (1 << CH) - 1));
      step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, the number of independent input channels (1..32).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 500000, the debounce threshold D in clk cycles (1..2^24-1).
REQ-003 The block SHALL have parameter RESET_LEVEL, default 1'b0, the reset value of every synchroniser stage and level output.
REQ-004 The block SHALL have port clk  input  1  the system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port asynch_nreset  input  1  the asynchronous, active-low reset.
REQ-006 The block SHALL have port signal_input  input  CHANNELS  the raw asynchronous inputs, one bit per channel.
REQ-007 The block SHALL have port signal_output  output  CHANNELS  the debounced level per channel.
REQ-008 The block SHALL have port rise_pulse  output  CHANNELS  a one-cycle strobe per channel on a debounced 0->1 transition.
REQ-009 The block SHALL have port fall_pulse  output  CHANNELS  a one-cycle strobe per channel on a debounced 1->0 transition.

Function
REQ-010 Each channel SHALL be fully independent: a two-flop synchroniser (s0, s1), a counter of width clog2(D+1), a level register and the pulse registers.
REQ-011 On each edge, s0 SHALL take signal_input[i] and s1 SHALL take the previous s0.
REQ-012 When s0 != s1 before an edge, the counter SHALL load 0 at that edge.
REQ-013 Otherwise, the counter SHALL increment by 1 per edge and saturate at D without wrapping.
REQ-014 When the counter == D before an edge, the level register SHALL load s1 at that edge; otherwise it SHALL hold.
REQ-015 Latency: for a new input level first sampled into s0 at edge k and held stable, signal_output SHALL change at edge k+D+2.
REQ-016 Any input pulse shorter than D+1 cycles SHALL leave signal_output unchanged.
REQ-017 Each such pulse SHALL restart the count from 0.
REQ-018 rise_pulse[i] SHALL be 1 for exactly the one cycle following the edge at which signal_output[i] goes 0->1, and 0 otherwise.
REQ-019 fall_pulse[i] SHALL be 1 for exactly the one cycle following the edge at which signal_output[i] goes 1->0, and 0 otherwise.
REQ-020 The pulses SHALL be registered, aligned with the new level.
REQ-021 When the counter saturates with s1 equal to the current level, no level change and no pulse SHALL occur.
REQ-022 Simultaneous transitions on several channels SHALL be debounced independently with identical per-channel timing.
REQ-023 All outputs SHALL be driven directly from flops, with no combinational path from signal_input.

Reset
REQ-024 While asynch_nreset = 0, every s0, s1 and signal_output bit SHALL equal RESET_LEVEL.
REQ-025 While asynch_nreset = 0, all counters SHALL be 0, and rise_pulse and fall_pulse SHALL be all-zero.
REQ-026 Reset assertion SHALL take effect immediately, independent of clk, including mid-count; any partial count SHALL be discarded.
REQ-027 After reset release, no pulse SHALL be generated unless a debounced level differing from RESET_LEVEL is established per REQ-015.

Configuration
REQ-028 Macro MULTI_DEBOUNCER_EDGE_EN defined: rise_pulse and fall_pulse SHALL be generated per REQ-018..REQ-020.
REQ-029 Macro MULTI_DEBOUNCER_EDGE_EN undefined: rise_pulse and fall_pulse SHALL be tied to constant 0, with their registers removed.
REQ-030 With MULTI_DEBOUNCER_EDGE_EN undefined, signal_output behaviour SHALL be identical to the defined case.

Verification
REQ-031 Clean step: CHANNELS=4, D=4, ch0 0->1 sampled at edge 10 and held -> signal_output[0]=1 after edge 16; rise_pulse[0]=1 for one cycle only; other channels stay 0.
REQ-032 Glitch rejection: D=4, ch1 high for 3 cycles then low -> signal_output[1] stays 0 and no pulses occur.
REQ-033 Bounce then settle: D=4, ch2 toggles each cycle for 8 cycles then holds 1 -> signal_output[2] rises exactly D+2 edges after the last toggle sample; exactly one rise_pulse occurs.
REQ-034 Simultaneous channels: all 4 channels rise at the same edge -> all outputs rise on the same edge with 4 concurrent rise pulses.
REQ-035 Falling edge plus reset mid-count: established 1 on ch3, input 0 for 2 cycles, then asynch_nreset pulsed low -> all outputs 0 immediately, counters 0, no fall_pulse.
REQ-036 Macro off: scenario REQ-031 rerun without MULTI_DEBOUNCER_EDGE_EN -> identical signal_output timing; rise_pulse and fall_pulse constant 0.
